// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and default constants for the FIFO-fed UART transmitter.
// The PARITY encoding is always reserved, even when FIFO_UART_TX_PARITY_EN is undefined.
package fifo_uart_pkg;

  localparam int unsigned DEF_CLK_DIV   = 868;
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the synchronous FIFO and the UART transmitter.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_rd_en;

  // master: the transmitter that pops; slave: the FIFO being drained
  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module uart_baud_cnt #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO, 8N1/8N2 by default.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS = DEF_STOP_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  localparam int unsigned   IW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic baud_en;
  logic bit_tick;

  assign baud_en = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (baud_en),
    .tick  (bit_tick)
  );

  // tx_d is the line level for the next state, so tx itself is a plain flop
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo.fifo_empty) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d  = fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo.fifo_data;
`endif
        idx_d    = '0;
        tx_d     = 1'b0;
        state_d  = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign tx_done         = done_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- UART transmitter directly downstream of the team's synchronous FIFO (`fifo`, WIDTH=8).
- Pops one byte at a time using the FIFO's `rd_en`/`empty` interface, serializes it 8N1 (or 8E1/8E2), and drives the line.
- Sits at the chip's serial egress; the FIFO buffers bursts from the core, and this block drains them at baud rate.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
- DATA_BITS, 8, payload bits per frame; must equal FIFO WIDTH
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- fifo_empty  input  1  FIFO `empty` flag
- fifo_data  input  DATA_BITS  FIFO `data_out`; valid the cycle after `fifo_rd_en` is high
- fifo_rd_en  output  1  FIFO `rd_en`; one-cycle pulse per byte
- tx  output  1  serial line; idle high
- busy  output  1  high whenever the FSM is not in IDLE
- tx_done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (async, rst_n=0): tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts the frame immediately; the line returns high.
- All outputs are registered or decoded from registered state (Moore). There is no combinational path from input to output.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (only with the macro), STOP.
- IDLE: tx=1. If fifo_empty=0, go to FETCH.
- FETCH: fifo_rd_en=1 for exactly this one cycle; next state LOAD.
- LOAD: capture fifo_data into the shift register; next state START. The FIFO's `empty` update lands during FETCH/LOAD and is ignored there, so there is never a double pop.
- START: tx=0 for CLK_DIV cycles.
- DATA: tx=shift[0], LSB first. Shift right every CLK_DIV cycles. DATA_BITS bits total, index 0..DATA_BITS-1. Then go to PARITY or STOP.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then go to IDLE. tx_done=1 on the first IDLE cycle.
- Baud counter: width $clog2(CLK_DIV). Counts 0..CLK_DIV-1. Wraps to 0 and generates a bit tick at CLK_DIV-1. Held at 0 in IDLE/FETCH/LOAD.
- Latency: fifo_empty falling in cycle N -> fifo_rd_en high at N+1 -> tx falls at N+3.
- Back-to-back: with FIFO non-empty at frame end, the gap is exactly 3 extra idle-high cycles (IDLE, FETCH, LOAD) between the end of the stop bit and the next start bit.
- fifo_empty is sampled only in IDLE. Changes during a frame have no effect.
- FIFO full/overflow is the producer's concern. This block never reads when fifo_empty=1.

Optional Feature:
- Macro FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, lasting CLK_DIV cycles.
  - tx = even parity = XOR of all payload bits, computed from the value captured in LOAD.
  - Frame = 1 + DATA_BITS + 1 + STOP_BITS bits.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - Frame = 1 + DATA_BITS + STOP_BITS bits.
  - The parity register and logic are absent.

Decomposition:
- Package fifo_uart_pkg holds:
  - typedef enum for the FSM states (PARITY encoding always reserved)
  - default constants for CLK_DIV/DATA_BITS/STOP_BITS
- Sub-module uart_baud_cnt is natural:
  - Parameter CLK_DIV.
  - Inputs: clk, rst_n, en.
  - Output: tick.
  - Counter cleared when en=0.

Test Plan (sim with CLK_DIV=4, STOP_BITS=1 unless noted):
- Reset hold: rst_n=0 for 5 cycles, fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
- Single byte 0xA5: fifo_empty falls at cycle 10 -> rd_en pulse at cycle 11 only. tx=0 during cycles 13-16. Data bits LSB-first 1,0,1,0,0,1,0,1, 4 cycles each. Stop high cycles 49-52. tx_done at cycle 53.
- Back-to-back 0x00 then 0xFF with FIFO pre-loaded -> two rd_en pulses 43 cycles apart (40-cycle frame + 3-cycle gap). The second frame's data bits are all 1.
- Empty FIFO: fifo_empty=1 for 100 cycles -> no rd_en, tx=1, busy=0.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 in the same cycle (async). After release with fifo_empty=1, stays IDLE.
- FIFO_UART_TX_PARITY_EN defined, byte 0x07 (three ones) -> parity bit=1 for 4 cycles after bit 7, then the stop bit. With STOP_BITS=2, the stop bits are high for 8 cycles.
